matvec_sequencer: RTL and testbench



---
 rtl/matvec_pkg.sv | 22 ++
 rtl/matvec_sequencer_dot_product.sv | 39 +++
 rtl/matvec_sequencer.sv | 155 +++++++++++++++
 tb/tb_matvec_sequencer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
// Shared types and constants for the matrix-vector sequencer and its dot-product engine.
package matvec_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned LANE_W = 32;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned ROW_W  = LANES * LANE_W;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StCapture,
    StOutput
  } seq_state_t;

  function automatic logic [LANE_W-1:0] get_lane(input logic [ROW_W-1:0] row,
                                                 input int unsigned idx);
    return row[idx*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/matvec_sequencer_dot_product.sv
// 8-lane unsigned dot-product engine, fixed latency of one cycle from start to done.
module dot_product
  import matvec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [LANE_W-1:0] a      [LANES],
  input  logic [LANE_W-1:0] b      [LANES],
  output logic              done,
  output logic [RES_W-1:0]  result
);

  logic             done_q;
  logic [RES_W-1:0] result_q;
  logic [RES_W-1:0] sum;

  // Sum wraps modulo 2^RES_W; each lane product fits exactly in RES_W bits.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      sum = sum + RES_W'(a[i]) * RES_W'(b[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= start;
      if (start) result_q <= sum;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: rtl/matvec_sequencer.sv
// Command-driven y = M*x sequencer: fetches rows, drives the dot-product engine, streams results.
module matvec_sequencer
  import matvec_pkg::*;
#(
  parameter int unsigned ROWS_MAX = 64,
  parameter int unsigned ADDR_W   = $clog2(ROWS_MAX)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W:0]   cmd_rows,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ROW_W-1:0]  cmd_x,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [ROW_W-1:0]  mem_rd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic [ADDR_W:0]   res_index,
  output logic              res_last,
  output logic              cmd_done,
  output logic              busy
);

  localparam logic [ADDR_W:0] RowsMax = (ADDR_W+1)'(ROWS_MAX);
  localparam logic [ADDR_W:0] RowOne  = (ADDR_W+1)'(1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W:0]   row_q, row_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ROW_W-1:0]  x_q, x_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [ADDR_W:0]   res_index_q, res_index_d;
  logic              res_last_q, res_last_d;
  logic              cmd_done_q, cmd_done_d;
  logic [ADDR_W:0]   rows_clamped;

  logic              eng_done;
  logic [RES_W-1:0]  eng_result;
  logic [LANE_W-1:0] a_lanes [LANES];
  logic [LANE_W-1:0] b_lanes [LANES];

  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      a_lanes[i] = get_lane(mem_rd_data, i);
      b_lanes[i] = get_lane(x_q, i);
    end
  end

  dot_product u_engine (
    .clock  (clock),
    .reset  (reset),
    .start  (state_q == StIssue),
    .a      (a_lanes),
    .b      (b_lanes),
    .done   (eng_done),
    .result (eng_result)
  );

  assign rows_clamped = (cmd_rows > RowsMax) ? RowsMax : cmd_rows;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    count_d     = count_q;
    base_d      = base_q;
    x_d         = x_q;
    res_data_d  = res_data_q;
    res_index_d = res_index_q;
    res_last_d  = res_last_q;
    cmd_done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          x_d     = cmd_x;
          base_d  = cmd_base;
          count_d = rows_clamped;
          row_d   = '0;
          if (rows_clamped == '0) cmd_done_d = 1'b1;
          else                    state_d    = StFetch;
        end
      end
      StFetch: state_d = StIssue;
      StIssue: state_d = StCapture;
      StCapture: begin
        res_data_d  = eng_result;
        res_index_d = row_q;
        res_last_d  = (row_q == count_q - RowOne);
        state_d     = StOutput;
      end
      StOutput: begin
        if (res_ready) begin
          if (res_last_q) begin
            state_d    = StIdle;
            cmd_done_d = 1'b1;
          end else begin
            row_d   = row_q + RowOne;
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A coincident handshake still delivers; only the completion pulse is suppressed.
    if (abort && state_q != StIdle) begin
      state_d    = StIdle;
      cmd_done_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      row_q       <= '0;
      count_q     <= '0;
      base_q      <= '0;
      x_q         <= '0;
      res_data_q  <= '0;
      res_index_q <= '0;
      res_last_q  <= 1'b0;
      cmd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      count_q     <= count_d;
      base_q      <= base_d;
      x_q         <= x_d;
      res_data_q  <= res_data_d;
      res_index_q <= res_index_d;
      res_last_q  <= res_last_d;
      cmd_done_q  <= cmd_done_d;
    end
  end

  // abort outranks a new command while idle
  assign cmd_ready   = (state_q == StIdle) && !abort;
  assign busy        = (state_q != StIdle);
  assign mem_rd_en   = (state_q == StFetch);
  assign mem_rd_addr = (state_q == StFetch) ? base_q + row_q[ADDR_W-1:0] : '0;
  assign res_valid   = (state_q == StOutput);
  assign res_data    = res_data_q;
  assign res_index   = res_index_q;
  assign res_last    = res_last_q;
  assign cmd_done    = cmd_done_q;

  capture_has_done: assert property (@(posedge clock) disable iff (reset)
                                     (state_q == StCapture) |-> eng_done);

endmodule

// File: tb/tb_matvec_sequencer.sv
// Scoreboard bench for matvec_sequencer: expected rows queued at command time, popped on handshake.
module tb_matvec_sequencer;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [6:0]   cmd_rows;
  logic [5:0]   cmd_base;
  logic [255:0] cmd_x;
  logic         abort;
  logic         mem_rd_en;
  logic [5:0]   mem_rd_addr;
  logic [255:0] mem_rd_data;
  logic         res_valid;
  logic         res_ready;
  logic [63:0]  res_data;
  logic [6:0]   res_index;
  logic         res_last;
  logic         cmd_done;
  logic         busy;

  typedef struct {
    logic [63:0] d;
    logic [6:0]  idx;
    logic        last;
  } exp_t;

  exp_t         sb[$];
  logic [5:0]   rd_log[$];
  logic [255:0] mem [64];
  int           n_checks = 0;
  int           n_fail   = 0;

  always #5 clock = ~clock;

  matvec_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rows    (cmd_rows),
    .cmd_base    (cmd_base),
    .cmd_x       (cmd_x),
    .abort       (abort),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_index   (res_index),
    .res_last    (res_last),
    .cmd_done    (cmd_done),
    .busy        (busy)
  );

  // Synchronous row memory: data one cycle after the read strobe.
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  always @(negedge clock) if (mem_rd_en) rd_log.push_back(mem_rd_addr);

  function automatic logic [63:0] dot_ref(input logic [255:0] r, input logic [255:0] x);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) acc = acc + 64'(r[i*32 +: 32]) * 64'(x[i*32 +: 32]);
    return acc;
  endfunction

  task automatic push_cmd(input int rows, input int base, input logic [255:0] x);
    for (int k = 0; k < rows; k++) begin
      exp_t e;
      e.d    = dot_ref(mem[(base + k) % 64], x);
      e.idx  = 7'(k);
      e.last = (k == rows - 1);
      sb.push_back(e);
    end
  endtask

  // Called at a falling edge with the DUT idle; returns one cycle later (FETCH visible).
  task automatic do_cmd(input logic [6:0] rows, input logic [5:0] base, input logic [255:0] x);
    cmd_valid = 1'b1;
    cmd_rows  = rows;
    cmd_base  = base;
    cmd_x     = x;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({cmd_ready, busy, mem_rd_en, res_valid, res_last, cmd_done} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/busy/rd/val/last/done=%b required 100000",
               {cmd_ready, busy, mem_rd_en, res_valid, res_last, cmd_done});
    end
    n_checks++;
    if (mem_rd_addr !== 6'd0 || res_data !== 64'd0 || res_index !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_data: got addr=%0d data=%h idx=%0d required 0/0/0",
               mem_rd_addr, res_data, res_index);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single;
    logic [255:0] x;
    exp_t         e;
    for (int i = 0; i < 8; i++) mem[0][i*32 +: 32] = 32'(i + 1);
    x = {8{32'd2}};
    sb.delete();
    push_cmd(1, 0, x);
    do_cmd(7'd1, 6'd0, x);
    n_checks++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL single_fetch: got en=%b addr=%0d at T+1 required 1/0", mem_rd_en, mem_rd_addr);
    end
    repeat (3) @(negedge clock);
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: got res_valid=%b at T+4 required 1", res_valid);
    end
    e = sb.pop_front();
    n_checks++;
    if (res_data !== 64'd72 || res_data !== e.d || res_index !== e.idx || res_last !== e.last) begin
      n_fail++;
      $display("FAIL single_result: got data=%0d idx=%0d last=%b required 72/0/1",
               res_data, res_index, res_last);
    end
    @(negedge clock);
    n_checks++;
    if (cmd_done !== 1'b1 || cmd_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got done/ready/valid=%b%b%b at T+5 required 110",
               cmd_done, cmd_ready, res_valid);
    end
    @(negedge clock);
    n_checks++;
    if (cmd_done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done_pulse: got cmd_done=%b at T+6 required 0", cmd_done);
    end
  endtask

  task automatic test_backpressure;
    logic [255:0] x;
    logic [63:0]  held;
    exp_t         e;
    int           stall = 0;
    int           got   = 0;
    bit           done_seen = 1'b0;
    for (int r = 10; r < 13; r++)
      for (int i = 0; i < 8; i++) mem[r][i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    held = '0;
    sb.delete();
    push_cmd(3, 10, x);
    do_cmd(7'd3, 6'd10, x);
    for (int c = 0; c < 80 && !done_seen; c++) begin
      @(negedge clock);
      if (cmd_done) done_seen = 1'b1;
      if (res_valid && res_index == 7'd1 && stall < 5) begin
        res_ready = 1'b0;
        if (stall > 0) begin
          n_checks++;
          if (res_data !== held) begin
            n_fail++;
            $display("FAIL bp_hold: got data=%h during stall required %h", res_data, held);
          end
        end
        n_checks++;
        if (mem_rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_no_read: got mem_rd_en=%b during stall required 0", mem_rd_en);
        end
        held = res_data;
        stall++;
      end else begin
        res_ready = 1'b1;
        if (res_valid) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL bp_extra: got unexpected result idx=%0d required none", res_index);
          end else begin
            e = sb.pop_front();
            got++;
            if (res_data !== e.d || res_index !== e.idx || res_last !== e.last) begin
              n_fail++;
              $display("FAIL bp_result: got data=%h idx=%0d last=%b required %h/%0d/%b",
                       res_data, res_index, res_last, e.d, e.idx, e.last);
            end
          end
        end
      end
    end
    res_ready = 1'b1;
    n_checks++;
    if (!done_seen || got != 3 || stall != 5) begin
      n_fail++;
      $display("FAIL bp_complete: got done=%b results=%0d stalls=%0d required 1/3/5",
               done_seen, got, stall);
    end
    @(negedge clock);
  endtask

  task automatic test_zero_rows;
    bit bad = 1'b0;
    do_cmd(7'd0, 6'd7, {8{32'd5}});
    n_checks++;
    if (cmd_done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: got done/ready/busy=%b%b%b at T+1 required 110",
               cmd_done, cmd_ready, busy);
    end
    for (int c = 0; c < 6; c++) begin
      if (mem_rd_en || res_valid) bad = 1'b1;
      @(negedge clock);
    end
    n_checks++;
    if (bad || cmd_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_quiet: got activity=%b done=%b required 0/0", bad, cmd_done);
    end
  endtask

  task automatic test_wrap;
    logic [255:0] x;
    logic [5:0]   exp_addr [4];
    exp_t         e;
    bit           done_seen = 1'b0;
    int           got = 0;
    exp_addr = '{6'd62, 6'd63, 6'd0, 6'd1};
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++) mem[exp_addr[k]][i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    sb.delete();
    rd_log.delete();
    push_cmd(4, 62, x);
    do_cmd(7'd4, 6'd62, x);
    for (int c = 0; c < 40 && !done_seen; c++) begin
      @(negedge clock);
      if (cmd_done) done_seen = 1'b1;
      if (res_valid && sb.size() > 0) begin
        e = sb.pop_front();
        got++;
        n_checks++;
        if (res_data !== e.d || res_index !== e.idx || res_last !== e.last) begin
          n_fail++;
          $display("FAIL wrap_result: got data=%h idx=%0d last=%b required %h/%0d/%b",
                   res_data, res_index, res_last, e.d, e.idx, e.last);
        end
      end
    end
    n_checks++;
    if (rd_log.size() != 4 || got != 4 || !done_seen) begin
      n_fail++;
      $display("FAIL wrap_count: got reads=%0d results=%0d done=%b required 4/4/1",
               rd_log.size(), got, done_seen);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (rd_log[k] !== exp_addr[k]) begin
          n_fail++;
          $display("FAIL wrap_addr%0d: got %0d required %0d", k, rd_log[k], exp_addr[k]);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic test_all_ones;
    mem[5] = {256{1'b1}};
    do_cmd(7'd1, 6'd5, {256{1'b1}});
    repeat (3) @(negedge clock);
    n_checks++;
    if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFF0_0000_0008) begin
      n_fail++;
      $display("FAIL all_ones: got valid=%b data=%h required 1/fffffff000000008",
               res_valid, res_data);
    end
    repeat (2) @(negedge clock);
  endtask

  // Abort (or reset) lands in CAPTURE of row 1 of a 3-row command.
  task automatic test_abort(input bit use_reset);
    logic [255:0] x;
    exp_t         e;
    int           fetches = 1;
    int           got = 0;
    bit           bad = 1'b0;
    for (int r = 20; r < 23; r++)
      for (int i = 0; i < 8; i++) mem[r][i*32 +: 32] = $urandom;
    for (int i = 0; i < 8; i++) x[i*32 +: 32] = $urandom;
    sb.delete();
    push_cmd(3, 20, x);
    do_cmd(7'd3, 6'd20, x);
    for (int c = 0; c < 30 && fetches < 2; c++) begin
      @(negedge clock);
      if (mem_rd_en) fetches++;
      if (res_valid) begin
        e = sb.pop_front();
        got++;
        n_checks++;
        if (res_data !== e.d || res_index !== e.idx || res_last !== e.last) begin
          n_fail++;
          $display("FAIL abort_row0: got data=%h idx=%0d last=%b required %h/%0d/%b",
                   res_data, res_index, res_last, e.d, e.idx, e.last);
        end
      end
    end
    repeat (2) @(negedge clock);
    if (use_reset) reset = 1'b1;
    else           abort = 1'b1;
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_done !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle(rst=%b): got busy/valid/done/rd=%b%b%b%b required 0000",
               use_reset, busy, res_valid, cmd_done, mem_rd_en);
    end
    if (use_reset) begin
      n_checks++;
      if (res_data !== 64'd0 || res_index !== 7'd0 || res_last !== 1'b0 ||
          mem_rd_addr !== 6'd0 || cmd_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_midcmd: got data=%h idx=%0d last=%b addr=%0d rdy=%b required 0/0/0/0/1",
                 res_data, res_index, res_last, mem_rd_addr, cmd_ready);
      end
    end
    reset = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (cmd_done || res_valid || busy || mem_rd_en) bad = 1'b1;
    end
    n_checks++;
    if (bad || got != 1) begin
      n_fail++;
      $display("FAIL abort_quiet(rst=%b): got activity=%b results=%0d required 0/1",
               use_reset, bad, got);
    end
    sb.delete();
  endtask

  task automatic test_abort_idle;
    abort     = 1'b1;
    cmd_valid = 1'b1;
    cmd_rows  = 7'd2;
    cmd_base  = 6'd0;
    @(negedge clock);
    abort     = 1'b0;
    cmd_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_over_cmd: got busy=%b rd=%b required 0/0", busy, mem_rd_en);
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_rows  = '0;
    cmd_base  = '0;
    cmd_x     = '0;
    abort     = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    @(negedge clock);
    test_reset();
    test_single();
    test_backpressure();
    test_zero_rows();
    test_wrap();
    test_all_ones();
    test_abort(1'b0);
    test_abort(1'b1);
    test_abort_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
